// File: rtl/uart_btn_pkg.sv
// uart_btn_pkg
//   Shared constants for the UART button sequencer: ASCII command bytes,
//   button bit positions, stopwatch and sequencer state encodings, and a
//   small helper used to size the press/gap counter.
package uart_btn_pkg;

    // ASCII command bytes
    localparam logic [7:0] KEY_U   = 8'h55;
    localparam logic [7:0] KEY_D   = 8'h44;
    localparam logic [7:0] KEY_L   = 8'h4C;
    localparam logic [7:0] KEY_R   = 8'h52;
    localparam logic [7:0] KEY_G   = 8'h47;
    localparam logic [7:0] KEY_S   = 8'h53;
    localparam logic [7:0] KEY_C   = 8'h43;
    localparam logic [7:0] KEY_ESC = 8'h1B;
    localparam logic [7:0] KEY_1   = 8'h31;
    localparam logic [7:0] KEY_4   = 8'h34;

    // Button bit positions; digit keys start at BTN_NUM0
    localparam int BTN_U    = 0;
    localparam int BTN_L    = 1;
    localparam int BTN_R    = 2;
    localparam int BTN_D    = 3;
    localparam int BTN_NUM0 = 4;

    typedef enum logic [1:0] {
        SW_STOP  = 2'b00,
        SW_RUN   = 2'b01,
        SW_CLEAR = 2'b10
    } sw_state_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_HOLD = 2'b01,
        SEQ_GAP  = 2'b10
    } seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo
//   Synchronous FIFO holding decoded button codes.
//   Ports:
//     clk, w_rst   clock, asynchronous active-high reset
//     flush_i      drop all entries on the next edge (wins over push/pop)
//     push_i       write wdata_i; ignored when full unless a pop happens too
//     pop_i        advance the read pointer; ignored when empty
//     wdata_i      code to store
//     rdata_o      head entry (combinational read)
//     full_o       no free slot
//     empty_o      no entry
module cmd_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             w_rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_btn_sequencer.sv
// uart_btn_sequencer
//   Turns ASCII bytes from the UART RX core into timed button presses.
//   Decoded codes are queued in cmd_fifo and played out one at a time as a
//   HOLD_CYCLES press followed by a GAP_CYCLES all-zero gap. A stopwatch
//   run-state tracker suppresses redundant G/S commands. ESC flushes
//   everything and returns to a clean idle state.
//   Optional feature: define UART_ECHO_EN to echo accepted bytes to a TX core.
//   Ports:
//     clk, w_rst   clock, asynchronous active-high reset
//     rx_done      one-cycle strobe, rx_data valid
//     rx_data      received byte
//     mode         0 watch key map, 1 stopwatch key map
//     btn_out      registered press vector (one-hot or zero)
//     sw_run       stopwatch tracker is in RUN
//     ovf          sticky, a command was dropped on a full queue
//     esc_pulse    one-cycle strobe after ESC
//     echo_start   echo request (UART_ECHO_EN only, else 0)
//     echo_data    echo byte (UART_ECHO_EN only, else 0)
//     tx_busy      TX core busy (UART_ECHO_EN only, else ignored)
module uart_btn_sequencer
    import uart_btn_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int HOLD_CYCLES = 100000,
    parameter int GAP_CYCLES  = 10000,
    parameter int CMD_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               w_rst,
    input  logic               rx_done,
    input  logic [7:0]         rx_data,
    input  logic               mode,
    output logic [NUM_BTN-1:0] btn_out,
    output logic               sw_run,
    output logic               ovf,
    output logic               esc_pulse,
    output logic               echo_start,
    output logic [7:0]         echo_data,
    input  logic               tx_busy
);

    localparam int CW = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]      GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [NUM_BTN-1:0] ONE       = NUM_BTN'(1);

    sw_state_e          sw_q;
    logic               sw_run_q;
    seq_state_e         seq_q;
    logic [CW-1:0]      cnt_q;
    logic [NUM_BTN-1:0] btn_q;
    logic               avail_q;
    logic               ovf_q;
    logic               esc_pulse_q;

    logic [NUM_BTN-1:0] dec_code;
    logic               dec_vld;
    logic               sw_g, sw_s, sw_c;
    logic               esc;
    logic               wr_req, drop, pop;
    logic [NUM_BTN-1:0] fifo_rdata;
    logic               fifo_full, fifo_empty;
    logic               gap_end;

    // ---------------------------------------------------------------- decode
    assign esc = rx_done && (rx_data == KEY_ESC);

    always_comb begin
        dec_code = '0;
        sw_g     = 1'b0;
        sw_s     = 1'b0;
        sw_c     = 1'b0;
        if (rx_done) begin
            if (!mode) begin
                case (rx_data)
                    KEY_U:   dec_code[BTN_U] = 1'b1;
                    KEY_L:   dec_code[BTN_L] = 1'b1;
                    KEY_R:   dec_code[BTN_R] = 1'b1;
                    KEY_D:   dec_code[BTN_D] = 1'b1;
                    default: begin
                        // Digit keys only exist on builds wide enough for them.
                        if ((rx_data >= KEY_1) && (rx_data <= KEY_4) &&
                            (BTN_NUM0 + int'(rx_data - KEY_1) < NUM_BTN))
                            dec_code = ONE << (BTN_NUM0 + int'(rx_data - KEY_1));
                    end
                endcase
            end else begin
                if ((rx_data == KEY_G) && (sw_q == SW_STOP)) begin
                    sw_g            = 1'b1;
                    dec_code[BTN_R] = 1'b1;
                end else if ((rx_data == KEY_S) && (sw_q == SW_RUN)) begin
                    sw_s            = 1'b1;
                    dec_code[BTN_R] = 1'b1;
                end else if (rx_data == KEY_C) begin
                    sw_c            = 1'b1;
                    dec_code[BTN_L] = 1'b1;
                end
            end
        end
    end

    assign dec_vld = |dec_code;
    assign wr_req  = dec_vld && !esc;

    // ---------------------------------------------------------------- queue
    assign gap_end = (seq_q == SEQ_GAP) && (cnt_q == GAP_LAST);
    assign pop     = !esc && avail_q && !fifo_empty &&
                     ((seq_q == SEQ_IDLE) || gap_end);
    assign drop    = wr_req && fifo_full && !pop;

    cmd_fifo #(
        .WIDTH (NUM_BTN),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .w_rst   (w_rst),
        .flush_i (esc),
        .push_i  (wr_req),
        .pop_i   (pop),
        .wdata_i (dec_code),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---------------------------------------------------- stopwatch tracker
    // Updates even when the matching code is dropped, so the tracker follows
    // what the user typed rather than what was pressed.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            sw_q     <= SW_STOP;
            sw_run_q <= 1'b0;
        end else if (esc) begin
            sw_q     <= SW_STOP;
            sw_run_q <= 1'b0;
        end else if (sw_c) begin
            sw_q     <= SW_CLEAR;
            sw_run_q <= 1'b0;
        end else if (sw_g) begin
            sw_q     <= SW_RUN;
            sw_run_q <= 1'b1;
        end else if (sw_s) begin
            sw_q     <= SW_STOP;
            sw_run_q <= 1'b0;
        end else if (sw_q == SW_CLEAR) begin
            sw_q     <= SW_STOP;
            sw_run_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------ sequencer
    // The sequencer sees the queue through avail_q, a registered non-empty
    // flag: a code written at edge k is popped at k+2. The flag can be one
    // cycle stale after a pop, but pop points are always at least two edges
    // apart, and pop also checks the live empty flag.
    // A pop at the end of GAP loads the next press directly, so consecutive
    // presses are separated by exactly GAP_CYCLES zero cycles.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            seq_q   <= SEQ_IDLE;
            cnt_q   <= '0;
            btn_q   <= '0;
            avail_q <= 1'b0;
        end else if (esc) begin
            seq_q   <= SEQ_IDLE;
            cnt_q   <= '0;
            btn_q   <= '0;
            avail_q <= 1'b0;
        end else begin
            avail_q <= !fifo_empty;
            case (seq_q)
                SEQ_IDLE: begin
                    if (pop) begin
                        btn_q <= fifo_rdata;
                        cnt_q <= '0;
                        seq_q <= SEQ_HOLD;
                    end
                end
                SEQ_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        btn_q <= '0;
                        cnt_q <= '0;
                        seq_q <= (GAP_CYCLES == 0) ? SEQ_IDLE : SEQ_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SEQ_GAP: begin
                    if (gap_end) begin
                        cnt_q <= '0;
                        if (pop) begin
                            btn_q <= fifo_rdata;
                            seq_q <= SEQ_HOLD;
                        end else begin
                            seq_q <= SEQ_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: seq_q <= SEQ_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------- ovf / escape
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            ovf_q       <= 1'b0;
            esc_pulse_q <= 1'b0;
        end else begin
            esc_pulse_q <= esc;
            if (esc)       ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
        end
    end

    assign btn_out   = btn_q;
    assign sw_run    = sw_run_q;
    assign ovf       = ovf_q;
    assign esc_pulse = esc_pulse_q;

    // ----------------------------------------------------------------- echo
`ifdef UART_ECHO_EN
    logic       echo_acc;
    logic       echo_pend_q;
    logic [7:0] echo_byte_q;
    logic [7:0] echo_data_q;
    logic       echo_start_q;

    // ESC is echoed too; a byte arriving while one is pending replaces it.
    assign echo_acc = (wr_req && !drop) || esc;

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            echo_pend_q  <= 1'b0;
            echo_byte_q  <= '0;
            echo_data_q  <= '0;
            echo_start_q <= 1'b0;
        end else begin
            echo_start_q <= 1'b0;
            if (echo_acc) begin
                echo_byte_q <= rx_data;
                echo_pend_q <= 1'b1;
            end else if (echo_pend_q && !tx_busy) begin
                echo_start_q <= 1'b1;
                echo_data_q  <= echo_byte_q;
                echo_pend_q  <= 1'b0;
            end
        end
    end

    assign echo_start = echo_start_q;
    assign echo_data  = echo_data_q;
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign echo_start     = 1'b0;
    assign echo_data      = 8'h00;
`endif

endmodule

// File: tb/tb_uart_btn_sequencer.sv
module tb_uart_btn_sequencer;

    logic       clk = 1'b0;
    logic       w_rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       mode;
    logic [3:0] btn_out;
    logic       sw_run, ovf, esc_pulse, echo_start, tx_busy;
    logic [7:0] echo_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_btn_sequencer #(
        .NUM_BTN     (4),
        .HOLD_CYCLES (8),
        .GAP_CYCLES  (4),
        .CMD_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .w_rst      (w_rst),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .mode       (mode),
        .btn_out    (btn_out),
        .sw_run     (sw_run),
        .ovf        (ovf),
        .esc_pulse  (esc_pulse),
        .echo_start (echo_start),
        .echo_data  (echo_data),
        .tx_busy    (tx_busy)
    );

    // Press log: code, first high sample, first low sample after it.
    logic [3:0] prev_btn = 4'h0;
    int         ncyc = 0;
    logic [3:0] code_q[$];
    int         start_q[$];
    int         end_q[$];

    always @(negedge clk) begin
        if (btn_out !== prev_btn) begin
            if (prev_btn != 4'h0) end_q.push_back(ncyc);
            if (btn_out != 4'h0) begin
                code_q.push_back(btn_out);
                start_q.push_back(ncyc);
            end
        end
        prev_btn = btn_out;
        ncyc++;
    end

`ifndef UART_ECHO_EN
    logic echo_seen = 1'b0;
    always @(negedge clk) if (echo_start !== 1'b0 || echo_data !== 8'h00) echo_seen = 1'b1;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after an edge; the byte is sampled at the next edge.
    task automatic send(input logic [7:0] b, input logic m);
        rx_data = b;
        mode    = m;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    initial begin
        int n0;
        int bad;
        w_rst   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        mode    = 1'b0;
        tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst btn_out", 32'(btn_out), 32'h0);
        check("rst sw_run", 32'(sw_run), 32'h0);
        check("rst ovf", 32'(ovf), 32'h0);
        check("rst esc_pulse", 32'(esc_pulse), 32'h0);
        check("rst echo_start", 32'(echo_start), 32'h0);
        check("rst echo_data", 32'(echo_data), 32'h0);
        w_rst = 1'b0;
        repeat (3) cyc();

        // 1: single 'U', exact latency and hold length
        send(8'h55, 1'b0);
        check("s1 edge k", 32'(btn_out), 32'h0);
        cyc();
        check("s1 edge k+1", 32'(btn_out), 32'h0);
        cyc();
        check("s1 edge k+2", 32'(btn_out), 32'h1);
        bad = 0;
        repeat (7) begin
            cyc();
            if (btn_out !== 4'h1) bad++;
        end
        check("s1 held k+3..k+9", 32'(bad), 32'h0);
        cyc();
        check("s1 edge k+10", 32'(btn_out), 32'h0);
        check("s1 ovf", 32'(ovf), 32'h0);
        repeat (10) cyc();

        // 2: U, D, R back to back
        n0 = code_q.size();
        send(8'h55, 1'b0);
        send(8'h44, 1'b0);
        send(8'h52, 1'b0);
        repeat (50) cyc();
        check("s2 press count", 32'(code_q.size() - n0), 32'd3);
        if (code_q.size() >= n0 + 3 && end_q.size() >= n0 + 3) begin
            check("s2 code0", 32'(code_q[n0]), 32'h1);
            check("s2 code1", 32'(code_q[n0+1]), 32'h8);
            check("s2 code2", 32'(code_q[n0+2]), 32'h4);
            for (int i = 0; i < 3; i++)
                check($sformatf("s2 len%0d", i), 32'(end_q[n0+i] - start_q[n0+i]), 32'd8);
            check("s2 gap01", 32'(start_q[n0+1] - end_q[n0]), 32'd4);
            check("s2 gap12", 32'(start_q[n0+2] - end_q[n0+1]), 32'd4);
        end

        // 3: stopwatch G,G,S,S,C
        n0 = code_q.size();
        send(8'h47, 1'b1);
        check("s3 sw_run after G", 32'(sw_run), 32'h1);
        repeat (15) cyc();
        send(8'h47, 1'b1);
        check("s3 sw_run after 2nd G", 32'(sw_run), 32'h1);
        send(8'h53, 1'b1);
        check("s3 sw_run after S", 32'(sw_run), 32'h0);
        send(8'h53, 1'b1);
        send(8'h43, 1'b1);
        check("s3 sw_run after C", 32'(sw_run), 32'h0);
        repeat (60) cyc();
        check("s3 sw_run later", 32'(sw_run), 32'h0);
        check("s3 press count", 32'(code_q.size() - n0), 32'd3);
        if (code_q.size() >= n0 + 3) begin
            check("s3 code0", 32'(code_q[n0]), 32'h4);
            check("s3 code1", 32'(code_q[n0+1]), 32'h4);
            check("s3 code2", 32'(code_q[n0+2]), 32'h2);
        end

        // 4: six 'L' back to back, one dropped
        n0 = code_q.size();
        repeat (5) send(8'h4C, 1'b0);
        check("s4 ovf at full", 32'(ovf), 32'h0);
        send(8'h4C, 1'b0);
        check("s4 ovf on drop", 32'(ovf), 32'h1);
        repeat (80) cyc();
        check("s4 press count", 32'(code_q.size() - n0), 32'd5);
        bad = 0;
        for (int i = n0; i < code_q.size(); i++) if (code_q[i] !== 4'h2) bad++;
        check("s4 codes all L", 32'(bad), 32'h0);
        check("s4 ovf sticky", 32'(ovf), 32'h1);

        // 5: ESC mid-HOLD with two entries queued
        send(8'h47, 1'b1);
        send(8'h4C, 1'b0);
        send(8'h4C, 1'b0);
        for (int i = 0; i < 20 && btn_out == 4'h0; i++) cyc();
        check("s5 in flight", 32'(btn_out), 32'h4);
        cyc();
        cyc();
        send(8'h1B, 1'b0);
        n0 = code_q.size();
        check("s5 btn cleared", 32'(btn_out), 32'h0);
        check("s5 ovf cleared", 32'(ovf), 32'h0);
        check("s5 esc_pulse", 32'(esc_pulse), 32'h1);
        check("s5 sw_run", 32'(sw_run), 32'h0);
        cyc();
        check("s5 esc_pulse 1 cycle", 32'(esc_pulse), 32'h0);
        repeat (60) cyc();
        check("s5 no further presses", 32'(code_q.size() - n0), 32'd0);
        check("s5 press closed", 32'(end_q.size()), 32'(start_q.size()));

        // 6: echo
`ifdef UART_ECHO_EN
        tx_busy = 1'b1;
        cyc();
        send(8'h44, 1'b0);
        bad = 0;
        repeat (5) begin
            cyc();
            if (echo_start !== 1'b0) bad++;
        end
        check("s6 held while busy", 32'(bad), 32'h0);
        tx_busy = 1'b0;
        cyc();
        check("s6 echo_start", 32'(echo_start), 32'h1);
        check("s6 echo_data", 32'(echo_data), 32'h44);
        cyc();
        check("s6 echo one cycle", 32'(echo_start), 32'h0);
        repeat (20) cyc();
`else
        check("s6 echo inactive", 32'(echo_seen), 32'h0);
`endif

        // Asynchronous reset in the middle of a press
        send(8'h55, 1'b0);
        send(8'h52, 1'b0);
        for (int i = 0; i < 20 && btn_out == 4'h0; i++) cyc();
        check("rst-mid pressing", 32'(btn_out), 32'h1);
        cyc();
        #2;
        w_rst = 1'b1;
        #1;
        check("rst-mid async clear", 32'(btn_out), 32'h0);
        @(posedge clk);
        #1;
        w_rst = 1'b0;
        n0 = code_q.size();
        repeat (30) cyc();
        check("rst-mid no resume", 32'(code_q.size() - n0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
